// File: rtl/adder_result_accumulator.sv
// Block accumulator for 9-bit adder results with handshaked block output.
// Define ADDER_ACC_SATURATE_EN to saturate on overflow instead of wrapping.
module adder_result_accumulator #(
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [7:0]       sum_in,
  input  logic             carry_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       count_out,
  output logic             ovf_out,
  output logic             valid_out,
  input  logic             ready_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   v;
  logic [ACC_W:0]   t;
  logic [7:0]       cnt_inc;

  assign v       = {{(ACC_W-8){1'b0}}, carry_in, sum_in};
  assign t       = {1'b0, acc_q} + v;
  assign cnt_inc = cnt_q + 8'd1;
  assign accept  = valid_in && ready_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = (BLOCK_LEN == 1) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (accept && cnt_inc == 8'(BLOCK_LEN))
          state_d = DONE;
      end
      DONE: begin
        if (ready_out)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // acc/ovf survive the DONE->IDLE handshake; only the next accept clears them
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = v[ACC_W-1:0];
          cnt_d = 8'd1;
          ovf_d = 1'b0;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (t[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef ADDER_ACC_SATURATE_EN
            acc_d = '1;
`else
            acc_d = t[ACC_W-1:0];
`endif
          end else begin
            acc_d = t[ACC_W-1:0];
          end
        end
      end
      DONE: begin
        if (ready_out)
          cnt_d = 8'd0;
      end
      default: cnt_d = 8'd0;
    endcase
  end

  always_comb begin
    ready_in  = (state_q != DONE);
    valid_out = (state_q == DONE);
  end

  assign acc_out   = acc_q;
  assign count_out = cnt_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Scoreboard bench: default, ACC_W=10 and BLOCK_LEN=1 instances.
// Expected block totals come from a bench-side model of the accumulator.
module tb_adder_result_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid [3];
  logic       carry [3];
  logic       rdo   [3];
  logic [7:0] sum   [3];

  logic [15:0] acc0, acc2;
  logic [9:0]  acc1;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic        ovf0, ovf1, ovf2;
  logic        vo0, vo1, vo2;
  logic        ri0, ri1, ri2;

  always #5 clk = ~clk;

  adder_result_accumulator u0 (
    .clk_in(clk), .rst_n_in(rst_n),
    .sum_in(sum[0]), .carry_in(carry[0]),
    .valid_in(valid[0]), .ready_in(ri0),
    .acc_out(acc0), .count_out(cnt0),
    .ovf_out(ovf0), .valid_out(vo0),
    .ready_out(rdo[0])
  );

  adder_result_accumulator #(.ACC_W(10)) u1 (
    .clk_in(clk), .rst_n_in(rst_n),
    .sum_in(sum[1]), .carry_in(carry[1]),
    .valid_in(valid[1]), .ready_in(ri1),
    .acc_out(acc1), .count_out(cnt1),
    .ovf_out(ovf1), .valid_out(vo1),
    .ready_out(rdo[1])
  );

  adder_result_accumulator #(.BLOCK_LEN(1)) u2 (
    .clk_in(clk), .rst_n_in(rst_n),
    .sum_in(sum[2]), .carry_in(carry[2]),
    .valid_in(valid[2]), .ready_in(ri2),
    .acc_out(acc2), .count_out(cnt2),
    .ovf_out(ovf2), .valid_out(vo2),
    .ready_out(rdo[2])
  );

  typedef struct {
    int     idx;
    longint acc;
    bit     ovf;
  } exp_t;

  exp_t   sbq [$];
  longint macc [3];
  bit     movf [3];
  int     mcnt [3];
  int     errs = 0;
  int     checks = 0;

  task automatic check(input string tag,
                       input longint act,
                       input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  function automatic int wof(input int i);
    return (i == 1) ? 10 : 16;
  endfunction

  function automatic int lof(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic longint get_acc(input int i);
    case (i)
      0:       return longint'(acc0);
      1:       return longint'(acc1);
      default: return longint'(acc2);
    endcase
  endfunction

  function automatic longint get_cnt(input int i);
    case (i)
      0:       return longint'(cnt0);
      1:       return longint'(cnt1);
      default: return longint'(cnt2);
    endcase
  endfunction

  function automatic longint get_ovf(input int i);
    case (i)
      0:       return longint'(ovf0);
      1:       return longint'(ovf1);
      default: return longint'(ovf2);
    endcase
  endfunction

  function automatic longint get_vo(input int i);
    case (i)
      0:       return longint'(vo0);
      1:       return longint'(vo1);
      default: return longint'(vo2);
    endcase
  endfunction

  function automatic longint get_ri(input int i);
    case (i)
      0:       return longint'(ri0);
      1:       return longint'(ri1);
      default: return longint'(ri2);
    endcase
  endfunction

  task automatic model_accept(input int i, input longint v);
    longint mask, t;
    mask = (64'd1 << wof(i)) - 1;
    if (mcnt[i] == 0) begin
      macc[i] = v;
      movf[i] = 1'b0;
      mcnt[i] = 1;
    end else begin
      t = macc[i] + v;
      if (t > mask) begin
        movf[i] = 1'b1;
`ifdef ADDER_ACC_SATURATE_EN
        macc[i] = mask;
`else
        macc[i] = t & mask;
`endif
      end else begin
        macc[i] = t;
      end
      mcnt[i]++;
    end
  endtask

  task automatic send(input int i, input logic [8:0] v,
                      input int gap);
    int n;
    exp_t e;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    valid[i] = 1'b1;
    {carry[i], sum[i]} = v;
    n = 0;
    while (get_ri(i) == 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50)
      check("ready_in_timeout", get_ri(i), 1);
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
    model_accept(i, longint'(v));
    check("count", get_cnt(i), mcnt[i]);
    check("acc_run", get_acc(i), macc[i]);
    check("ovf_run", get_ovf(i), movf[i]);
    if (mcnt[i] == lof(i)) begin
      e.idx = i;
      e.acc = macc[i];
      e.ovf = movf[i];
      sbq.push_back(e);
      check("valid_rise", get_vo(i), 1);
      mcnt[i] = 0;
    end else begin
      check("valid_low", get_vo(i), 0);
    end
  endtask

  task automatic collect(input int i, input int hold);
    int n;
    exp_t e;
    n = 0;
    while (get_vo(i) == 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("valid_out", get_vo(i), 1);
    check("ready_in_done", get_ri(i), 0);
    if (sbq.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      check("sb_idx", i, e.idx);
      check("blk_acc", get_acc(i), e.acc);
      check("blk_ovf", get_ovf(i), e.ovf);
      repeat (hold) begin
        valid[i] = 1'b1;
        {carry[i], sum[i]} = 9'($urandom);
        @(posedge clk);
        #1;
        check("hold_acc", get_acc(i), e.acc);
        check("hold_cnt", get_cnt(i), lof(i));
        check("hold_valid", get_vo(i), 1);
        check("hold_ready", get_ri(i), 0);
      end
      valid[i] = 1'b0;
      rdo[i] = 1'b1;
      @(posedge clk);
      #1;
      rdo[i] = 1'b0;
      check("post_valid", get_vo(i), 0);
      check("post_ready", get_ri(i), 1);
      check("post_cnt", get_cnt(i), 0);
      check("post_acc", get_acc(i), e.acc);
    end
  endtask

  task automatic do_reset(input int edges);
    rst_n = 1'b0;
    repeat (edges) begin
      for (int i = 0; i < 3; i++) begin
        valid[i] = 1'($urandom);
        rdo[i]   = 1'($urandom);
        {carry[i], sum[i]} = 9'($urandom);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      rdo[i]   = 1'b0;
      mcnt[i]  = 0;
      check("rst_acc", get_acc(i), 0);
      check("rst_cnt", get_cnt(i), 0);
      check("rst_ovf", get_ovf(i), 0);
      check("rst_valid", get_vo(i), 0);
      check("rst_ready", get_ri(i), 1);
    end
    sbq.delete();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      rdo[i]   = 1'b0;
      carry[i] = 1'b0;
      sum[i]   = 8'h00;
    end
    do_reset(2);

    send(0, 9'h010, 0);
    send(0, 9'h020, 0);
    send(0, 9'h1FF, 0);
    send(0, 9'h001, 0);
    check("basic_acc", get_acc(0), 'h230);
    collect(0, 3);

    for (int k = 0; k < 4; k++)
      send(0, 9'($urandom_range(0, 511)),
           $urandom_range(0, 3));
    collect(0, 1);

    repeat (4) send(1, 9'h1FF, 0);
`ifdef ADDER_ACC_SATURATE_EN
    check("ovf_sat_acc", get_acc(1), 'h3FF);
`else
    check("ovf_wrap_acc", get_acc(1), 'h3FC);
`endif
    check("ovf_flag", get_ovf(1), 1);
    collect(1, 0);
    repeat (4) send(1, 9'h001, 0);
    check("ovf_clear", get_ovf(1), 0);
    collect(1, 2);

    send(0, 9'h033, 0);
    send(0, 9'h044, 1);
    do_reset(1);
    repeat (4) send(0, 9'h005, 0);
    check("after_rst_acc", get_acc(0), 'h14);
    collect(0, 0);

    for (int k = 0; k < 3; k++) begin
      send(2, 9'h1AB, k);
      check("b1_acc", get_acc(2), 'h1AB);
      collect(2, 2);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
